// File: rtl/picorv32_soc_pkg.sv
// Shared SoC constants: debug-bridge opcodes and status, FSM state encoding, AXI RESP codes.
package picorv32_soc_pkg;

    localparam logic [7:0] DBG_OPC_WRITE  = 8'h01;
    localparam logic [7:0] DBG_OPC_READ   = 8'h02;
    localparam logic [7:0] DBG_STAT_ERROR = 8'hFF;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_TX_STAT,
        ST_TX_DATA
    } dbg_state_e;

endpackage

// File: rtl/axi_lite_dbg_master.sv
// Byte-stream debug bridge: decodes read/write command frames into single AXI-lite
// transactions and returns a status byte (plus read data) on the response stream.
module axi_lite_dbg_master
    import picorv32_soc_pkg::*;
#(
    parameter int unsigned AXI_ADDR_BW_p = 32,
    parameter int unsigned AXI_DATA_BW_p = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_valid,
    output logic                     o_rx_ready,

    output logic [7:0]               o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,

    output logic [AXI_ADDR_BW_p-1:0] o_axi_awaddr,
    output logic                     o_axi_awvalid,
    output logic [2:0]               o_axi_awprot,
    input  logic                     i_axi_awready,
    output logic [AXI_DATA_BW_p-1:0] o_axi_wdata,
    output logic [3:0]               o_axi_wstrb,
    output logic                     o_axi_wvalid,
    input  logic                     i_axi_wready,
    input  logic [1:0]               i_axi_bresp,
    input  logic                     i_axi_bvalid,
    output logic                     o_axi_bready,
    output logic [AXI_ADDR_BW_p-1:0] o_axi_araddr,
    output logic                     o_axi_arvalid,
    output logic [2:0]               o_axi_arprot,
    input  logic                     i_axi_arready,
    input  logic [AXI_DATA_BW_p-1:0] i_axi_rdata,
    input  logic [1:0]               i_axi_rresp,
    input  logic                     i_axi_rvalid,
    output logic                     o_axi_rready,

    output logic                     o_busy
);

    localparam int unsigned FRAME_W = 32;

    dbg_state_e         state_q;
    logic [1:0]         cnt_q;
    logic               is_rd_q;
    logic [FRAME_W-1:0] addr_q;
    logic [FRAME_W-1:0] wdata_q;
    logic [FRAME_W-1:0] rdata_q;
    logic               rx_ready_q;
    logic [7:0]         tx_data_q;
    logic               tx_valid_q;
    logic               awvalid_q;
    logic               wvalid_q;
    logic               bready_q;
    logic               arvalid_q;
    logic               rready_q;
    logic               busy_q;

    logic rx_fire_c;
    logic tx_fire_c;
    logic aw_ok_c;
    logic w_ok_c;

    assign rx_fire_c = i_rx_valid && rx_ready_q;
    assign tx_fire_c = tx_valid_q && i_tx_ready;
    // A channel counts as complete once its valid has dropped or it handshakes this edge.
    assign aw_ok_c   = !awvalid_q || i_axi_awready;
    assign w_ok_c    = !wvalid_q  || i_axi_wready;

    // Frame decode, AXI sequencing and response serialisation; every output is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            is_rd_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rx_ready_q <= 1'b1;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_fire_c) begin
                        busy_q <= 1'b1;
                        cnt_q  <= 2'd0;
                        if (i_rx_data == DBG_OPC_WRITE || i_rx_data == DBG_OPC_READ) begin
                            is_rd_q <= (i_rx_data == DBG_OPC_READ);
                            state_q <= ST_ADDR;
                        end else begin
                            is_rd_q    <= 1'b0;
                            rx_ready_q <= 1'b0;
                            tx_data_q  <= DBG_STAT_ERROR;
                            tx_valid_q <= 1'b1;
                            state_q    <= ST_TX_STAT;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_fire_c) begin
                        // Little-endian: each new byte enters at the top and shifts down.
                        addr_q <= {i_rx_data, addr_q[FRAME_W-1:8]};
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if (is_rd_q) begin
                                rx_ready_q <= 1'b0;
                                arvalid_q  <= 1'b1;
                                state_q    <= ST_RD_REQ;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_fire_c) begin
                        wdata_q <= {i_rx_data, wdata_q[FRAME_W-1:8]};
                        cnt_q   <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            rx_ready_q <= 1'b0;
                            awvalid_q  <= 1'b1;
                            wvalid_q   <= 1'b1;
                            state_q    <= ST_WR_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (awvalid_q && i_axi_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && i_axi_wready)   wvalid_q  <= 1'b0;
                    if (aw_ok_c && w_ok_c) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (i_axi_bvalid) begin
                        bready_q   <= 1'b0;
                        tx_data_q  <= {6'b0, i_axi_bresp};
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_TX_STAT;
                    end
                end
                ST_RD_REQ: begin
                    if (i_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (i_axi_rvalid) begin
                        rready_q   <= 1'b0;
                        rdata_q    <= FRAME_W'(i_axi_rdata);
                        tx_data_q  <= {6'b0, i_axi_rresp};
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_TX_STAT;
                    end
                end
                ST_TX_STAT: begin
                    if (tx_fire_c) begin
                        if (is_rd_q) begin
                            tx_data_q <= rdata_q[7:0];
                            cnt_q     <= 2'd0;
                            state_q   <= ST_TX_DATA;
                        end else begin
                            tx_valid_q <= 1'b0;
                            rx_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
                    end
                end
                ST_TX_DATA: begin
                    if (tx_fire_c) begin
                        cnt_q   <= cnt_q + 2'd1;
                        rdata_q <= {8'h00, rdata_q[FRAME_W-1:8]};
                        if (cnt_q == 2'd3) begin
                            tx_valid_q <= 1'b0;
                            rx_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= ST_IDLE;
                        end else begin
                            tx_data_q <= rdata_q[15:8];
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rx_ready    = rx_ready_q;
    assign o_tx_data     = tx_data_q;
    assign o_tx_valid    = tx_valid_q;
    assign o_axi_awaddr  = AXI_ADDR_BW_p'(addr_q);
    assign o_axi_awvalid = awvalid_q;
    assign o_axi_awprot  = 3'b000;
    assign o_axi_wdata   = AXI_DATA_BW_p'(wdata_q);
    assign o_axi_wstrb   = 4'hF;
    assign o_axi_wvalid  = wvalid_q;
    assign o_axi_bready  = bready_q;
    assign o_axi_araddr  = AXI_ADDR_BW_p'(addr_q);
    assign o_axi_arvalid = arvalid_q;
    assign o_axi_arprot  = 3'b000;
    assign o_axi_rready  = rready_q;
    assign o_busy        = busy_q;

endmodule
